// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_sequencer
//  Purpose  : Instruction-fetch controller. Owns the PC, drives the ROM
//             address and fills the IF/ID register under stall, flush,
//             redirect, debug halt/resume and fetch-fault sequencing.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
  parameter int unsigned               DATA_WIDTH   = 32,
  parameter int unsigned               MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_VECTOR = 32'h00400000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Instruction,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] ifid_instruction,
  output logic [DATA_WIDTH-1:0] ifid_pc4,
  output logic                  ifid_valid,
  output logic                  halted,
  output logic                  fault
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  localparam logic [DATA_WIDTH-1:0] WINDOW_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic [DATA_WIDTH-1:0] w_pc_plus4;
  logic [DATA_WIDTH-1:0] w_candidate;
  logic [DATA_WIDTH-1:0] w_offset;
  logic                  w_legal;

  assign w_pc_plus4  = pc_q + DATA_WIDTH'(4);
  assign w_candidate = redirect ? redirect_target : w_pc_plus4;
  // Window test as an unsigned offset from the base: one compare covers both bounds.
  assign w_offset    = w_candidate - RESET_VECTOR;
  assign w_legal     = (w_candidate[1:0] == 2'b00) && (w_offset < WINDOW_BYTES);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;

    case (state_q)
      ST_RUN: begin
        if (redirect || flush) begin
          ifid_valid_d = 1'b0;
        end else if (!stall) begin
          ifid_instr_d = Instruction;
          ifid_pc4_d   = w_pc_plus4;
          ifid_valid_d = 1'b1;
        end

        if (redirect || !stall) begin
          if (w_legal) begin
            pc_d = w_candidate;
          end else begin
            state_d = ST_FAULT;
          end
        end

        if ((state_d != ST_FAULT) && halt_req) begin
          state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        ifid_valid_d = 1'b0;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        ifid_valid_d = 1'b0;
      end
    endcase

    halted_d = (state_d != ST_RUN);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_VECTOR;
      ifid_instr_q <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      fault_q      <= fault_d;
    end
  end

  assign PC               = pc_q;
  assign ifid_instruction = ifid_instr_q;
  assign ifid_pc4         = ifid_pc4_q;
  assign ifid_valid       = ifid_valid_q;
  assign halted           = halted_q;
  assign fault            = fault_q;

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the pipelined MIPS core. It owns the program counter and drives the address of the combinational program memory (ROM). It captures the returned instruction into the IF/ID pipeline register with a valid bit. It also sequences fetch under stall, flush, branch/jump redirect, debug halt/resume, and out-of-range or misaligned address faults.

## Interface
Parameters:
- DATA_WIDTH, 32, width of addresses and instructions
- MEMORY_DEPTH, 32, ROM size in words; valid fetch window is [RESET_VECTOR, RESET_VECTOR + 4*MEMORY_DEPTH)
- RESET_VECTOR, 32'h00400000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Instruction  in  DATA_WIDTH  ROM read data for address PC (combinational, same cycle)
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash IF/ID contents (valid to 0)
- redirect  in  1  branch/jump taken
- redirect_target  in  DATA_WIDTH  new PC when redirect=1
- halt_req  in  1  debug halt request (level)
- resume  in  1  debug resume pulse
- PC  out  DATA_WIDTH  fetch address to ROM
- ifid_instruction  out  DATA_WIDTH  IF/ID instruction
- ifid_pc4  out  DATA_WIDTH  IF/ID PC+4
- ifid_valid  out  1  IF/ID holds a real instruction
- halted  out  1  state is HALTED or FAULT
- fault  out  1  sticky fetch fault

## Operation
- States: RUN, HALTED, FAULT. Reset enters RUN.
- Reset values: PC=RESET_VECTOR, ifid_instruction=0, ifid_pc4=0, ifid_valid=0, halted=0, fault=0.
- Next-PC candidate: redirect_target if redirect=1, else PC+4.
  - Arithmetic is modulo 2^DATA_WIDTH.
  - Redirect overrides stall for the PC.
- Candidate legality: the candidate is illegal if it is misaligned (bits [1:0]≠0) or outside the fetch window.
- RUN, IF/ID update (priority order):
  - redirect or flush: ifid_valid←0; instruction/pc4 fields hold.
  - else stall: hold all fields.
  - else: load Instruction, PC+4, valid←1.
- RUN, PC update:
  - If redirect, or if stall=0: legal candidate → PC←candidate. Illegal candidate → PC holds and go to FAULT.
  - Otherwise (stall=1, no redirect): PC holds.
- RUN, halt: halt_req=1 with no fault → HALTED. The PC update and IF/ID capture of that cycle still occur.
- RUN, priority: fault has priority over halt_req.
- HALTED:
  - PC holds; ifid_valid←0 every cycle; halted=1.
  - resume=1 → RUN.
  - resume wins over a still-asserted halt_req for one cycle; halt_req is re-sampled in RUN.
- FAULT:
  - PC holds at the last legal address; ifid_valid←0; halted=1; fault=1.
  - Exit only via reset; resume is ignored.
- Reset assertion at any time asynchronously forces the reset values and RUN, regardless of in-flight redirect or stall.

## Timing
- Fetch latency: PC valid in cycle n; ROM data is combinational; captured at the end of n; ifid_valid=1 in cycle n+1.
- Redirect in cycle n: PC=target in n+1; ifid_valid=0 in n+1 (wrong-path squash); target instruction valid in n+2.
- Stall in cycle n: PC, ifid_* identical in n+1.
- halt_req sampled in cycle n: halted=1 in n+1. resume in cycle m: halted=0 in m+1; next valid instruction in m+2.
- Fault detected in cycle n: fault=halted=1 in n+1.
- All outputs registered except PC-to-ROM, which is the PC register itself (no combinational input→output path).

## Test plan
- Sequential fetch: release reset, no stalls → PC 0x00400000, 0x00400004, …; ifid_valid=1 from 2nd cycle with ifid_pc4=0x00400004 and ROM word 0.
- Stall for 3 cycles at PC 0x00400008 → PC and ifid_* frozen 3 cycles; fetch resumes at 0x0040000C.
- Redirect to 0x00400040 while stall=1 → PC=0x00400040 next cycle; ifid_valid=0; ROM word 16 valid one cycle later.
- Redirect to 0x00400042 (misaligned) or 0x00400080 → fault=1, halted=1, PC holds; resume ignored; reset clears.
- Run off end: sequential fetch reaches 0x0040007C → word 31 captured valid; next cycle FAULT with PC=0x0040007C.
- Halt/resume plus reset mid-operation:
  - halt_req at PC 0x00400010 → bubbles, PC held. resume → word 4 (fetch at 0x00400010) valid two cycles later.
  - Asserting reset mid-redirect forces PC=0x00400000 and ifid_valid=0 immediately.
